// File: rtl/framing_pkg.sv
// Shared framing-chain definitions: encoder state encoding, default K=7 generators, coded word width.
package framing_pkg;

    localparam int WORD_W = 16;

    // MSB of each generator taps the current input bit, LSB taps the oldest (delay 6)
    localparam logic [6:0] G0_DEF = 7'o133;
    localparam logic [6:0] G1_DEF = 7'o171;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENCODE = 2'd1,
        ST_TAIL   = 2'd2
    } enc_state_t;

endpackage

// File: rtl/conv_enc_byte.sv
// Rate-1/2 K=7 encoding of one byte, bit 0 first, as eight chained combinational steps.
// Latency: 0 (purely combinational). Backpressure: none.
// Flow: sr_in is the shift register before bit 0, sr_out after bit 7.
module conv_enc_byte
    import framing_pkg::*;
#(
    parameter logic [6:0] G0 = G0_DEF,
    parameter logic [6:0] G1 = G1_DEF
) (
    input  logic [7:0]        din,
    input  logic [5:0]        sr_in,
    output logic [WORD_W-1:0] word,
    output logic [5:0]        sr_out
);

    always_comb begin
        logic [5:0] sr;
        logic [6:0] win;
        sr   = sr_in;
        win  = '0;
        word = '0;
        for (int i = 0; i < 8; i++) begin
            // win[6] is the current bit, win[6-k] the bit delayed k
            win           = {din[i], sr[0], sr[1], sr[2], sr[3], sr[4], sr[5]};
            word[2*i]     = ^(win & G0);
            word[2*i+1]   = ^(win & G1);
            sr            = {sr[4:0], din[i]};
        end
        sr_out = sr;
    end

endmodule

// File: rtl/conv_encoder.sv
// Frame-level rate-1/2 K=7 convolutional encoder with zero-flush tail word; optional CONV_BYTE_COUNT_EN.
// Latency: 1 clk din -> dout; N encoded bytes produce N+1 words.
// Backpressure: none, one word per clk.
module conv_encoder
    import framing_pkg::*;
#(
    parameter logic [6:0] G0 = G0_DEF,
    parameter logic [6:0] G1 = G1_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        din,
    input  logic              indicator,
    output logic [WORD_W-1:0] dout,
    output logic              next_indicator
`ifdef CONV_BYTE_COUNT_EN
    ,
    output logic [15:0]       byte_count
`endif
);

    enc_state_t        state, state_nx;
    logic [5:0]        sr, sr_nx;
    logic [WORD_W-1:0] dout_nx;
    logic              next_indicator_nx;
    logic              first, first_nx;
    logic [7:0]        enc_din;
    logic [WORD_W-1:0] enc_word;
    logic [5:0]        enc_sr;

    // The tail flushes the shift register with zeros regardless of din
    assign enc_din = (state == ST_TAIL) ? 8'h00 : din;

    conv_enc_byte #(
        .G0 (G0),
        .G1 (G1)
    ) u_enc (
        .din    (enc_din),
        .sr_in  (sr),
        .word   (enc_word),
        .sr_out (enc_sr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            sr             <= '0;
            dout           <= '0;
            next_indicator <= 1'b0;
            first          <= 1'b0;
        end else begin
            state          <= state_nx;
            sr             <= sr_nx;
            dout           <= dout_nx;
            next_indicator <= next_indicator_nx;
            first          <= first_nx;
        end
    end

    always_comb begin
        state_nx          = ST_IDLE;
        sr_nx             = '0;
        dout_nx           = '0;
        next_indicator_nx = 1'b0;
        first_nx          = 1'b0;
        case (state)
            ST_IDLE: begin
                // The start-pulse byte is not encoded; the pulse rides out with the first word
                if (indicator) begin
                    state_nx = ST_ENCODE;
                    first_nx = 1'b1;
                end
            end
            ST_ENCODE: begin
                dout_nx           = enc_word;
                sr_nx             = enc_sr;
                next_indicator_nx = first;
                state_nx          = indicator ? ST_TAIL : ST_ENCODE;
            end
            ST_TAIL: begin
                dout_nx           = enc_word;
                next_indicator_nx = 1'b1;
                if (indicator) begin
                    state_nx = ST_ENCODE;
                    first_nx = 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

`ifdef CONV_BYTE_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_count <= '0;
        end else if (indicator && (state == ST_IDLE || state == ST_TAIL)) begin
            byte_count <= '0;
        end else if (state == ST_ENCODE && byte_count != 16'hFFFF) begin
            byte_count <= byte_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder: scoreboarded words against a bit-serial reference encoder.
module tb_conv_encoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        indicator = 1'b0;
    logic [15:0] dout;
    logic        next_indicator;
`ifdef CONV_BYTE_COUNT_EN
    logic [15:0] byte_count;
`endif

    int nchk = 0;
    int npass = 0;
    int nfail = 0;
    logic [16:0] exp_q[$];
    logic [5:0]  msr = 6'd0;

    always #5 clk = ~clk;

    conv_encoder dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .din            (din),
        .indicator      (indicator),
        .dout           (dout),
        .next_indicator (next_indicator)
`ifdef CONV_BYTE_COUNT_EN
        ,
        .byte_count     (byte_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference encoder written from the default tap equations, one bit at a time
    function automatic logic [21:0] ref_enc(input logic [7:0] d, input logic [5:0] s_in);
        logic [5:0]  s;
        logic [15:0] w;
        logic        b;
        s = s_in;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            b          = d[i];
            w[2*i]     = b ^ s[1] ^ s[2] ^ s[4] ^ s[5];
            w[2*i+1]   = b ^ s[0] ^ s[1] ^ s[2] ^ s[5];
            s          = {s[4:0], b};
        end
        return {s, w};
    endfunction

    task automatic cycle(input logic [7:0] d, input logic ind, input logic [15:0] ew,
                         input logic en, input string tag);
        logic [16:0] e;
        @(negedge clk);
        din       = d;
        indicator = ind;
        exp_q.push_back({en, ew});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, "/dout"}, 32'(dout), 32'(e[15:0]));
        check({tag, "/next_indicator"}, 32'(next_indicator), 32'(e[16]));
    endtask

    task automatic start(input string tag);
        msr = 6'd0;
        cycle(8'hA5, 1'b1, 16'h0000, 1'b0, tag);
    endtask

    task automatic enc_byte(input logic [7:0] d, input logic ind, input logic first, input string tag);
        logic [21:0] r;
        r   = ref_enc(d, msr);
        msr = r[21:16];
        cycle(d, ind, r[15:0], first, tag);
    endtask

    task automatic tail(input logic ind, input string tag);
        logic [21:0] r;
        r   = ref_enc(8'h00, msr);
        msr = 6'd0;
        cycle(8'hFF, ind, r[15:0], 1'b1, tag);
    endtask

    initial begin
        din = 8'hA5;
        repeat (2) @(posedge clk);
        #1;
        check("reset/dout", 32'(dout), 32'h0);
        check("reset/next_indicator", 32'(next_indicator), 32'h0);
`ifdef CONV_BYTE_COUNT_EN
        check("reset/byte_count", 32'(byte_count), 32'h0);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 3; i++) cycle(8'hA5, 1'b0, 16'h0000, 1'b0, "idle");

        // single 0x01 byte then a 0x00 end byte
        start("start1");
        cycle(8'h01, 1'b0, 16'h34FB, 1'b1, "f1_w1");
        cycle(8'h00, 1'b1, 16'h0000, 1'b0, "f1_w2");
        cycle(8'hFF, 1'b0, 16'h0000, 1'b1, "f1_tail");
        cycle(8'hA5, 1'b0, 16'h0000, 1'b0, "f1_idle");

        // one byte carrying the end pulse
        start("start2");
        cycle(8'h80, 1'b1, 16'hC000, 1'b1, "f2_w1");
        cycle(8'hFF, 1'b0, 16'h0D3E, 1'b1, "f2_tail");
        cycle(8'hA5, 1'b0, 16'h0000, 1'b0, "f2_idle");

        // multi-byte frame, then a new start during the tail
        start("start3");
        enc_byte(8'h3C, 1'b0, 1'b1, "f3_w1");
        enc_byte(8'hD2, 1'b0, 1'b0, "f3_w2");
        enc_byte(8'h7E, 1'b1, 1'b0, "f3_w3");
        tail(1'b1, "f3_tail_restart");
        cycle(8'h01, 1'b0, 16'h34FB, 1'b1, "f4_w1");
        cycle(8'h00, 1'b1, 16'h0000, 1'b0, "f4_w2");
        cycle(8'hFF, 1'b0, 16'h0000, 1'b1, "f4_tail");
        cycle(8'hA5, 1'b0, 16'h0000, 1'b0, "f4_idle");

        // reset in the middle of a frame
        start("start5");
        cycle(8'h80, 1'b0, 16'hC000, 1'b1, "f5_w1");
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset/dout", 32'(dout), 32'h0);
        check("midreset/next_indicator", 32'(next_indicator), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        cycle(8'hA5, 1'b0, 16'h0000, 1'b0, "post_reset_idle");
        start("start6");
        cycle(8'h01, 1'b0, 16'h34FB, 1'b1, "f6_w1");
        cycle(8'h00, 1'b1, 16'h0000, 1'b0, "f6_w2");
        cycle(8'hFF, 1'b0, 16'h0000, 1'b1, "f6_tail");

`ifdef CONV_BYTE_COUNT_EN
        // 300-byte frame with pseudo-random payload
        start("start7");
        check("count/after_start", 32'(byte_count), 32'h0);
        for (int i = 0; i < 300; i++)
            enc_byte(8'($urandom_range(0, 255)), (i == 299), (i == 0), "f7_w");
        check("count/last_byte", 32'(byte_count), 32'd300);
        tail(1'b0, "f7_tail");
        check("count/tail", 32'(byte_count), 32'd300);
        cycle(8'hA5, 1'b0, 16'h0000, 1'b0, "f7_idle");
        check("count/idle", 32'(byte_count), 32'd300);
        start("start8");
        check("count/cleared", 32'(byte_count), 32'h0);
`endif

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
